// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and ALU function codes for the shared-ALU sequencer.
package alu_share_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [5:0] FUN_EQ  = 6'b110011;
  localparam logic [5:0] FUN_NEQ = 6'b110001;
  localparam logic [5:0] FUN_LT  = 6'b110101;
  localparam logic [5:0] FUN_LEZ = 6'b111101;
  localparam logic [5:0] FUN_GTZ = 6'b111111;

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// Two-way round-robin grant; on a tie the requester that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: accept, execute one cycle,
// then hold the result on the owner's response handshake.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned FW = 6,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [DW-1:0] r0_a,
  input  logic [DW-1:0] r0_b,
  input  logic [FW-1:0] r0_fun,
  input  logic          r0_sign,
  output logic          r0_rvalid,
  input  logic          r0_rready,
  output logic [DW-1:0] r0_result,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [DW-1:0] r1_a,
  input  logic [DW-1:0] r1_b,
  input  logic [FW-1:0] r1_fun,
  input  logic          r1_sign,
  output logic          r1_rvalid,
  input  logic          r1_rready,
  output logic [DW-1:0] r1_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [FW-1:0] alu_fun,
  output logic          alu_sign,
  input  logic [DW-1:0] alu_s,
  output logic          busy,
  output logic [CW-1:0] gnt0_cnt,
  output logic [CW-1:0] gnt1_cnt
);

  state_t        state;
  logic          last_grant;
  logic          owner;
  logic [DW-1:0] result_q;
  logic [1:0]    gnt;
  logic          taken;

  rr_arb2 u_arb (
    .valid ({r1_valid, r0_valid}),
    .last  (last_grant),
    .gnt   (gnt)
  );

  // Grant already implies valid, so ready alone marks an accept.
  assign r0_ready  = (state == IDLE) && gnt[0];
  assign r1_ready  = (state == IDLE) && gnt[1];
  assign r0_rvalid = (state == RESP) && !owner;
  assign r1_rvalid = (state == RESP) &&  owner;
  assign r0_result = result_q;
  assign r1_result = result_q;
  assign busy      = (state != IDLE);
  assign taken     = owner ? r1_rready : r0_rready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fun    <= '0;
      alu_sign   <= 1'b0;
      result_q   <= '0;
      gnt0_cnt   <= '0;
      gnt1_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_ready) begin
            alu_a    <= r0_a;
            alu_b    <= r0_b;
            alu_fun  <= r0_fun;
            alu_sign <= r0_sign;
            owner    <= 1'b0;
            if (gnt0_cnt != '1) gnt0_cnt <= gnt0_cnt + 1'b1;
            state    <= EXEC;
          end else if (r1_ready) begin
            alu_a    <= r1_a;
            alu_b    <= r1_b;
            alu_fun  <= r1_fun;
            alu_sign <= r1_sign;
            owner    <= 1'b1;
            if (gnt1_cnt != '1) gnt1_cnt <= gnt1_cnt + 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_s;
          state    <= RESP;
        end
        RESP: begin
          if (taken) begin
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU beside the DUT.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int unsigned CWT = 5;

  typedef struct {
    int          owner;
    logic [31:0] val;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  v, rr;
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [5:0]  pf [2];
  logic        ps [2];
  logic [31:0] pexp [2];

  logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid, busy, alu_sign;
  logic [31:0]   r0_result, r1_result, alu_a, alu_b, alu_s;
  logic [5:0]    alu_fun;
  logic [CWT-1:0] gnt0_cnt, gnt1_cnt;

  item_t sb [$];
  item_t rsp [$];
  int    order [$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  alu_share_ctrl #(.DW(32), .FW(6), .CW(CWT)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(v[0]), .r0_ready(r0_ready), .r0_a(pa[0]), .r0_b(pb[0]),
    .r0_fun(pf[0]), .r0_sign(ps[0]), .r0_rvalid(r0_rvalid), .r0_rready(rr[0]),
    .r0_result(r0_result),
    .r1_valid(v[1]), .r1_ready(r1_ready), .r1_a(pa[1]), .r1_b(pb[1]),
    .r1_fun(pf[1]), .r1_sign(ps[1]), .r1_rvalid(r1_rvalid), .r1_rready(rr[1]),
    .r1_result(r1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .alu_s(alu_s), .busy(busy), .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic s);
    case (f)
      FUN_ADD: return a + b;
      FUN_SUB: return a - b;
      FUN_AND: return a & b;
      FUN_OR:  return a | b;
      FUN_XOR: return a ^ b;
      FUN_NOR: return ~(a | b);
      FUN_SLL: return b << a[4:0];
      FUN_SRL: return b >> a[4:0];
      FUN_SRA: return $signed(b) >>> a[4:0];
      FUN_EQ:  return {31'b0, a == b};
      FUN_NEQ: return {31'b0, a != b};
      FUN_LT:  return {31'b0, s ? ($signed(a) < $signed(b)) : (a < b)};
      FUN_LEZ: return {31'b0, $signed(a) <= 0};
      FUN_GTZ: return {31'b0, $signed(a) > 0};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_s = alu_ref(alu_a, alu_b, alu_fun, alu_sign);

  task automatic set_op(input int r, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic s, input logic [31:0] e);
    pf[r] = f; pa[r] = a; pb[r] = b; ps[r] = s; pexp[r] = e; v[r] = 1'b1;
  endtask

  // One clock: record accepts (push expected) and response handshakes.
  task automatic tick();
    logic [1:0] acc;
    #1;
    acc[0] = v[0] & r0_ready;
    acc[1] = v[1] & r1_ready;
    for (int r = 0; r < 2; r++)
      if (acc[r]) begin
        sb.push_back(item_t'{owner: r, val: pexp[r]});
        order.push_back(r);
      end
    if (r0_rvalid && rr[0]) rsp.push_back(item_t'{owner: 0, val: r0_result});
    if (r1_rvalid && rr[1]) rsp.push_back(item_t'{owner: 1, val: r1_result});
    @(posedge clk);
    #1;
    if (acc[0]) v[0] = 1'b0;
    if (acc[1]) v[1] = 1'b0;
    cyc++;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    for (int i = 0; i < 40 && rsp.size() < n; i++) tick();
    ok = (rsp.size() >= n) && (sb.size() > 0);
  endtask

  task automatic pop_pair(output item_t got, output item_t exp);
    got = rsp.pop_front();
    exp = sb.pop_front();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    v = '0; rr = '0;
    sb.delete(); rsp.delete(); order.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {r0_ready, r1_ready, r0_rvalid, r1_rvalid, busy});
    end
    checks++;
    if (gnt0_cnt !== '0 || gnt1_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d required 0/0", gnt0_cnt, gnt1_cnt);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_fun !== 6'd0 || alu_sign !== 1'b0
        || r0_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_alu: got a=%h b=%h f=%h s=%b res=%h required zeros",
               alu_a, alu_b, alu_fun, alu_sign, r0_result);
    end
  endtask

  task automatic test_add();
    item_t got, exp;
    bit ok;
    set_op(0, FUN_ADD, 32'd5, 32'd7, 1'b0, 32'd12);
    #1;
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_ready: got %b%b required 10", r0_ready, r1_ready);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || r0_rvalid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_fun !== FUN_ADD) begin
      errors++;
      $display("FAIL add_exec: got busy=%b rvalid=%b a=%0d b=%0d f=%h required 1 0 5 7 00",
               busy, r0_rvalid, alu_a, alu_b, alu_fun);
    end
    tick();
    checks++;
    if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0 || r0_result !== 32'd12) begin
      errors++;
      $display("FAIL add_latency: got rvalid=%b/%b res=%0d required 1/0 12", r0_rvalid, r1_rvalid, r0_result);
    end
    rr = 2'b11;
    wait_rsp(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL add_rsp: got no response required one");
    end else begin
      pop_pair(got, exp);
      if (got.owner != exp.owner || got.val !== exp.val) begin
        errors++;
        $display("FAIL add_rsp: got owner %0d val %h required owner %0d val %h", got.owner, got.val, exp.owner, exp.val);
      end
    end
    checks++;
    if (gnt0_cnt !== 5'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_cnt: got cnt=%0d busy=%b required 1 0", gnt0_cnt, busy);
    end
  endtask

  task automatic test_sub();
    item_t got, exp;
    bit seen0 = 1'b0;
    rr = 2'b11;
    set_op(1, FUN_SUB, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 20 && rsp.size() == 0; i++) begin
      #1;
      if (r0_rvalid) seen0 = 1'b1;
      tick();
    end
    checks++;
    if (seen0) begin
      errors++;
      $display("FAIL sub_r0_quiet: got r0_rvalid=1 required 0");
    end
    checks++;
    if (rsp.size() == 0 || sb.size() == 0) begin
      errors++;
      $display("FAIL sub_rsp: got no response required one");
    end else begin
      pop_pair(got, exp);
      if (got.owner != 1 || got.val !== exp.val) begin
        errors++;
        $display("FAIL sub_rsp: got owner %0d val %h required owner 1 val %h", got.owner, got.val, exp.val);
      end
    end
    checks++;
    if (gnt1_cnt !== 5'd1) begin
      errors++;
      $display("FAIL sub_cnt: got %0d required 1", gnt1_cnt);
    end
  endtask

  task automatic test_pair();
    item_t got, exp;
    do_reset();
    rr = 2'b11;
    for (int p = 0; p < 2; p++) begin
      order.delete();
      if (p == 0) begin
        set_op(0, FUN_OR,  32'hF0, 32'h0F, 1'b0, 32'hFF);
        set_op(1, FUN_SLL, 32'd4,  32'd1,  1'b0, 32'd16);
      end else begin
        set_op(0, FUN_ADD, 32'd10,   32'd20,   1'b0, 32'd30);
        set_op(1, FUN_XOR, 32'hFF00, 32'h0FF0, 1'b0, 32'hF0F0);
      end
      #1;
      checks++;
      if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
        errors++;
        $display("FAIL pair%0d_grant: got %b%b required 10", p, r0_ready, r1_ready);
      end
      for (int i = 0; i < 40 && rsp.size() < 2; i++) tick();
      checks++;
      if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
        errors++;
        $display("FAIL pair%0d_order: got %0d accepts first=%0d required 2 accepts r0 then r1",
                 p, order.size(), (order.size() > 0) ? order[0] : -1);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rsp.size() == 0 || sb.size() == 0) begin
          errors++;
          $display("FAIL pair%0d_rsp%0d: got no response required one", p, k);
        end else begin
          pop_pair(got, exp);
          if (got.owner != exp.owner || got.val !== exp.val) begin
            errors++;
            $display("FAIL pair%0d_rsp%0d: got owner %0d val %h required owner %0d val %h",
                     p, k, got.owner, got.val, exp.owner, exp.val);
          end
        end
      end
    end
    checks++;
    if (gnt0_cnt !== 5'd2 || gnt1_cnt !== 5'd2) begin
      errors++;
      $display("FAIL pair_cnt: got %0d/%0d required 2/2", gnt0_cnt, gnt1_cnt);
    end
  endtask

  task automatic test_hold();
    item_t got, exp;
    bit ok;
    bit bad = 1'b0;
    rr = 2'b00;
    set_op(0, FUN_LT, 32'd3, 32'd5, 1'b1, 32'd1);
    tick();
    tick();
    set_op(1, FUN_ADD, 32'd2, 32'd3, 1'b0, 32'd5);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (r0_rvalid !== 1'b1 || r0_result !== 32'd1 || r1_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable: got rvalid=%b res=%0d r1_ready=%b required 1 1 0", r0_rvalid, r0_result, r1_ready);
    end
    rr[0] = 1'b1;
    tick();
    #1;
    checks++;
    if (r1_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_next_accept: got r1_ready=%b required 1", r1_ready);
    end
    rr = 2'b11;
    wait_rsp(2, ok);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rsp.size() == 0 || sb.size() == 0) begin
        errors++;
        $display("FAIL hold_rsp%0d: got no response required one", k);
      end else begin
        pop_pair(got, exp);
        if (got.owner != k || got.val !== exp.val) begin
          errors++;
          $display("FAIL hold_rsp%0d: got owner %0d val %h required owner %0d val %h", k, got.owner, got.val, k, exp.val);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    item_t got, exp;
    bit ok;
    bit seen = 1'b0;
    rr = 2'b11;
    set_op(0, FUN_ADD, 32'd1, 32'd1, 1'b0, 32'd2);
    tick();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || gnt0_cnt !== '0 || gnt1_cnt !== '0 || r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got busy=%b cnt=%0d/%0d rvalid=%b%b required 0 0/0 00",
               busy, gnt0_cnt, gnt1_cnt, r0_rvalid, r1_rvalid);
    end
    sb.delete(); rsp.delete(); v = '0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (r0_rvalid || r1_rvalid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen || rsp.size() != 0) begin
      errors++;
      $display("FAIL rstmid_dropped: got a response required none");
    end
    set_op(0, FUN_ADD, 32'd1, 32'd1, 1'b0, 32'd2);
    wait_rsp(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_next: got no response required one");
    end else begin
      pop_pair(got, exp);
      if (got.owner != 0 || got.val !== 32'd2) begin
        errors++;
        $display("FAIL rstmid_next: got owner %0d val %h required owner 0 val 2", got.owner, got.val);
      end
    end
    checks++;
    if (gnt0_cnt !== 5'd1) begin
      errors++;
      $display("FAIL rstmid_cnt: got %0d required 1", gnt0_cnt);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    item_t got, exp;
    int start;
    int sat_errs = 0;
    do_reset();
    rr = 2'b01;
    start = cyc;
    for (int i = 0; i < N; i++) begin
      set_op(0, FUN_ADD, i, 3 * i, 1'b0, 4 * i);
      for (int t = 0; t < 10 && v[0]; t++) tick();
      checks++;
      if (v[0]) begin
        errors++;
        $display("FAIL b2b_accept%0d: got no accept required accept", i);
        v[0] = 1'b0;
        break;
      end
      if (gnt0_cnt !== ((i + 1 < 31) ? CWT'(i + 1) : 5'd31)) sat_errs++;
    end
    checks++;
    if (sat_errs != 0 || gnt0_cnt !== 5'd31 || gnt1_cnt !== 5'd0) begin
      errors++;
      $display("FAIL b2b_saturate: got cnt=%0d/%0d with %0d bad steps required 31/0 and 0", gnt0_cnt, gnt1_cnt, sat_errs);
    end
    for (int i = 0; i < 40 && rsp.size() < N; i++) tick();
    checks++;
    if (cyc - start > 3 * N + 5) begin
      errors++;
      $display("FAIL b2b_rate: got %0d cycles required at most %0d", cyc - start, 3 * N + 5);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (rsp.size() == 0 || sb.size() == 0) begin
        errors++;
        $display("FAIL b2b_rsp%0d: got no response required one", k);
        break;
      end
      pop_pair(got, exp);
      if (got.owner != 0 || got.val !== 32'(4 * k)) begin
        errors++;
        $display("FAIL b2b_rsp%0d: got owner %0d val %h required owner 0 val %h", k, got.owner, got.val, 32'(4 * k));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    v = '0; rr = '0;
    for (int r = 0; r < 2; r++) begin
      pa[r] = '0; pb[r] = '0; pf[r] = '0; ps[r] = 1'b0; pexp[r] = '0;
    end
    test_reset();
    test_add();
    test_sub();
    test_pair();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
